// File: rtl/seq_normalizer_pkg.sv
// Shared definitions for the sequential normalizer: default widths and FSM state encoding.
package seq_normalizer_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = $clog2(WIDTH_DEF);

    localparam logic [1:0] STATE_IDLE_ENC  = 2'b00;
    localparam logic [1:0] STATE_SHIFT_ENC = 2'b01;
    localparam logic [1:0] STATE_DONE_ENC  = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = STATE_IDLE_ENC,
        SHIFT = STATE_SHIFT_ENC,
        DONE  = STATE_DONE_ENC
    } state_t;

endpackage : seq_normalizer_pkg

// File: rtl/seq_normalizer.sv
// Multi-cycle normalizer: shifts a word one bit per cycle until its leading bit is set.
// Optional macro SEQ_NORMALIZER_DIR_EN adds in_dir to select right (trailing-zero) normalization.
module seq_normalizer
    import seq_normalizer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
`ifdef SEQ_NORMALIZER_DIR_EN
    input  logic             in_dir,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_shift,
    output logic             out_zero
);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] work_reg, work_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             zero_reg, zero_next;

    logic [WIDTH-1:0] shift_step;
    logic             lead_bit;

`ifdef SEQ_NORMALIZER_DIR_EN
    logic dir_reg, dir_next;

    // Right normalization stops on bit 0, left normalization on the MSB.
    assign shift_step = dir_reg ? (work_reg >> 1) : (work_reg << 1);
    assign lead_bit   = dir_reg ? work_reg[0] : work_reg[WIDTH-1];
`else
    assign shift_step = work_reg << 1;
    assign lead_bit   = work_reg[WIDTH-1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            work_reg  <= '0;
            cnt_reg   <= '0;
            zero_reg  <= 1'b0;
`ifdef SEQ_NORMALIZER_DIR_EN
            dir_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            work_reg  <= work_next;
            cnt_reg   <= cnt_next;
            zero_reg  <= zero_next;
`ifdef SEQ_NORMALIZER_DIR_EN
            dir_reg   <= dir_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        work_next  = work_reg;
        cnt_next   = cnt_reg;
        zero_next  = zero_reg;
`ifdef SEQ_NORMALIZER_DIR_EN
        dir_next   = dir_reg;
`endif
        unique case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    work_next  = in_data;
                    cnt_next   = '0;
                    zero_next  = 1'b0;
`ifdef SEQ_NORMALIZER_DIR_EN
                    dir_next   = in_dir;
`endif
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (work_reg == '0) begin
                    // An all-zero word would never terminate; flag it and report no shift.
                    zero_next  = 1'b1;
                    cnt_next   = '0;
                    state_next = DONE;
                end else if (lead_bit) begin
                    state_next = DONE;
                end else begin
                    work_next = shift_step;
                    cnt_next  = cnt_reg + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign out_data  = work_reg;
    assign out_shift = cnt_reg;
    assign out_zero  = zero_reg;

endmodule : seq_normalizer

// File: tb/tb_seq_normalizer.sv
// Self-checking bench for seq_normalizer using an expected-result queue.
module tb_seq_normalizer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       in_dir = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [2:0] out_shift;
    logic       out_zero;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] din;
        logic       dir;
        logic [7:0] data;
        logic [2:0] shift;
        logic       zero;
        int         lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    seq_normalizer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef SEQ_NORMALIZER_DIR_EN
        .in_dir    (in_dir),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_shift (out_shift),
        .out_zero  (out_zero)
    );

    function automatic exp_t model(input logic [7:0] d, input logic dir);
        exp_t e;
        e.din   = d;
        e.dir   = dir;
        e.data  = d;
        e.shift = 3'd0;
        e.zero  = (d == 8'h00);
        e.lat   = 1;
        if (!e.zero) begin
            while (dir ? !e.data[0] : !e.data[7]) begin
                e.data  = dir ? (e.data >> 1) : (e.data << 1);
                e.shift = e.shift + 3'd1;
                e.lat   = e.lat + 1;
            end
        end
        return e;
    endfunction

    // Presents a word, waits (bounded) for in_ready, and pushes its expected result on accept.
    task automatic accept_word(input logic [7:0] d, input logic dir);
        bit ok = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_dir   = dir;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL accept_timeout: in_ready=%0b required 1 for word %02h", in_ready, d);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (ok) sb.push_back(model(d, dir));
    endtask

    // Waits for a result, holds it under backpressure for 'hold' cycles, then hands it off.
    task automatic collect(input string name, input int hold);
        exp_t e;
        int   cyc = 0;
        bit   seen = 0;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_queue: no expected entry available", name);
            return;
        end
        e = sb.pop_front();
        while (cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (out_valid) begin
                seen = 1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_timeout: out_valid never rose, required latency %0d", name, e.lat);
            return;
        end
        $display("txn %s: in=%02h dir=%0b out=%02h shift=%0d zero=%0b latency=%0d",
                 name, e.din, e.dir, out_data, out_shift, out_zero, cyc);
        n_checks++;
        if (cyc !== e.lat) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d required %0d", name, cyc, e.lat);
        end
        n_checks++;
        if (out_data !== e.data) begin
            n_fail++;
            $display("FAIL %s_data: got %02h required %02h", name, out_data, e.data);
        end
        n_checks++;
        if (out_shift !== e.shift) begin
            n_fail++;
            $display("FAIL %s_shift: got %0d required %0d", name, out_shift, e.shift);
        end
        n_checks++;
        if (out_zero !== e.zero) begin
            n_fail++;
            $display("FAIL %s_zero: got %0b required %0b", name, out_zero, e.zero);
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== e.data || out_shift !== e.shift ||
                out_zero !== e.zero || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_hold%0d: valid=%0b data=%02h shift=%0d zero=%0b rdy=%0b required 1/%02h/%0d/%0b/0",
                         name, h, out_valid, out_data, out_shift, out_zero, in_ready,
                         e.data, e.shift, e.zero);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_handoff: out_valid=%0b in_ready=%0b required 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00 ||
            out_shift !== 3'd0 || out_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%0b valid=%0b data=%02h shift=%0d zero=%0b required 1/0/00/0/0",
                     in_ready, out_valid, out_data, out_shift, out_zero);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_shift();
        accept_word(8'h2A, 1'b0);
        collect("shift2", 0);
        accept_word(8'h0B, 1'b0);
        collect("shift4", 0);
    endtask

    task automatic test_boundary();
        accept_word(8'h80, 1'b0);
        collect("msb_set", 0);
        accept_word(8'h01, 1'b0);
        collect("lsb_only", 0);
    endtask

    task automatic test_zero();
        accept_word(8'h00, 1'b0);
        collect("zero", 0);
    endtask

    task automatic test_backpressure();
        accept_word(8'h10, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        in_dir   = 1'b0;
        collect("bp_first", 5);
        // The held word must be taken on the first IDLE edge, right after handoff.
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sb.push_back(model(8'h55, 1'b0));
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_second_accept: in_ready=%0b required 0", in_ready);
        end
        collect("bp_second", 0);
    endtask

    task automatic test_reset_mid();
        bit leaked = 0;
        accept_word(8'h01, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        void'(sb.pop_back());
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00 ||
            out_shift !== 3'd0 || out_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: rdy=%0b valid=%0b data=%02h shift=%0d zero=%0b required 1/0/00/0/0",
                     in_ready, out_valid, out_data, out_shift, out_zero);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) leaked = 1;
        end
        n_checks++;
        if (leaked) begin
            n_fail++;
            $display("FAIL reset_mid_emit: out_valid=1 required 0 after reset");
        end
        accept_word(8'h40, 1'b0);
        collect("after_reset", 0);
    endtask

    task automatic test_dir();
        accept_word(8'h54, 1'b1);
        collect("dir_right", 0);
        accept_word(8'h54, 1'b0);
        collect("dir_left", 0);
        accept_word(8'h80, 1'b1);
        collect("dir_right_max", 0);
    endtask

    initial begin
        test_reset();
        test_shift();
        test_boundary();
        test_zero();
        test_backpressure();
        test_reset_mid();
`ifdef SEQ_NORMALIZER_DIR_EN
        test_dir();
`endif
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_seq_normalizer

// File: doc/seq_normalizer.md
# seq_normalizer

Multi-cycle normalizer, the inverse of the 8-bit barrel shifter. It accepts an 8-bit word and shifts it left one bit per cycle until the MSB is set. It returns the normalized word together with the shift amount, i.e. the shift count the barrel shifter would need to reproduce the result. It sits between a valid/ready producer and consumer in the datapath and feeds leading-zero counts to the shifter's shift_amount input.

## Interface
- WIDTH, 8, data width; must be a power of two, at least 2
- CNT_W, $clog2(WIDTH) = 3, shift-count width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  producer has a word
- in_ready  out  1  block can accept a word
- in_data  in  WIDTH  word to normalize
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- out_data  out  WIDTH  normalized word
- out_shift  out  CNT_W  number of positions shifted
- out_zero  out  1  input was all zeros

## Operation
- The FSM has three states: IDLE, SHIFT, DONE.
- **IDLE:** in_ready=1. If in_valid, the block loads in_data into the working register, clears the count to 0 and moves to SHIFT.
- **SHIFT, working reg == 0:** go to DONE with zero flag=1 and count=0.
- **SHIFT, working reg MSB == 1:** go to DONE.
- **SHIFT, otherwise:** shift reg left by 1 (zero fill), count+1, stay in SHIFT.
- The count never exceeds WIDTH-1, because a nonzero word reaches MSB=1 within WIDTH-1 shifts. No wrap occurs.
- **DONE:** out_valid=1 and out_data/out_shift/out_zero come from registers. When out_ready is high, return to IDLE.
- in_ready is derived combinationally as state==IDLE.
- Only one word is in flight at a time. There is no input/output overlap.

## Timing
- **Reset values:** IDLE state; working reg, count and out_zero = 0; out_valid=0; out_data=0; out_shift=0; out_zero=0. in_ready=1 once the state is IDLE.
- Reset is asynchronous and acts immediately in any state, including mid-SHIFT or DONE. The in-flight word is discarded and nothing is emitted.
- **Latency:** the word is accepted on edge t. With k shifts needed, DONE is entered on edge t+k+1, so out_valid is high from cycle t+k+1.
  - Minimum latency is 1 cycle (MSB already set, or zero input).
  - Maximum latency is WIDTH cycles (input 0x01).
- **Backpressure:** out_valid stays high and out_data/out_shift/out_zero stay stable until out_ready is sampled high.
- **Handoff:** on the handoff edge out_valid falls and in_ready rises in the next cycle. The earliest next accept is one cycle after handoff.
- in_valid is ignored outside IDLE. A held in_valid is accepted on the first IDLE cycle.
- out_ready is ignored outside DONE.

## Configuration
- The macro is `SEQ_NORMALIZER_DIR_EN`.
- **When defined:** the block adds port `in_dir` (in, 1 bit), sampled and stored at accept.
  - dir=0 behaves as the default left normalization.
  - dir=1 normalizes right: the block shifts right (zero fill) until bit 0 is set, and out_shift is the trailing-zero count.
  - The zero and latency rules are identical in both directions.
- **When undefined:** the in_dir port is absent and only left normalization is built.

## Structure
- **Package seq_normalizer_pkg:** WIDTH and CNT_W defaults, the state enum (IDLE, SHIFT, DONE) and the state encoding constants.
- There is no sub-module. The shift step and the MSB test are single expressions and live in the top module.

## Test plan
- **Shift by 2:** in_data=0x2A accepted at edge t -> out_valid from cycle t+3, out_data=0xA8, out_shift=2, out_zero=0.
- **Boundary inputs:**
  - in_data=0x80 -> out_valid from cycle t+1, out_data=0x80, out_shift=0.
  - in_data=0x01 -> out_valid from cycle t+8, out_data=0x80, out_shift=7.
- **Zero input:** in_data=0x00 -> out_valid from cycle t+1, out_data=0x00, out_shift=0, out_zero=1.
- **Backpressure:** run in_data=0x10 with out_ready held low for 5 cycles -> outputs stay stable (0x80, shift 3) and in_ready stays 0. A second word 0x55 is held on in_valid and is accepted only in the first IDLE cycle after handoff; its result is 0xAA, shift 1.
- **Reset mid-operation:** pulse rst 3 cycles after accepting 0x01 -> all outputs go to 0 and in_ready=1 immediately, and no result is emitted. The next word 0x40 yields 0x80, shift 1.
- **With SEQ_NORMALIZER_DIR_EN:** in_data=0x54, in_dir=1 -> out_data=0x15, out_shift=2. The same word with in_dir=0 -> 0xA8, shift 1.
